// File: rtl/db_read_sequencer_pkg.sv
// Shared types and defaults for the double-buffered read sequencer (memory core mode 3).
package db_seq_pkg;
  typedef enum logic [1:0] {IDLE, FILL, DRAIN, WAIT} state_t;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 16;
  localparam int CW_DEF = 32;

  localparam logic [1:0] MODE_DB = 2'h3;
endpackage

// File: rtl/db_read_sequencer_agen.sv
// 3-D nested iteration counter with running stride offsets; i0 is the innermost dimension.
module db_seq_agen
  import db_seq_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          step,
  input  logic [AW-1:0] start,
  input  logic [15:0]   stride_0,
  input  logic [15:0]   stride_1,
  input  logic [15:0]   stride_2,
  input  logic [CW-1:0] range_0,
  input  logic [CW-1:0] range_1,
  input  logic [CW-1:0] range_2,
  output logic [AW-1:0] addr,
  output logic          last_issue
);
  logic [CW-1:0] i0_q, i1_q, i2_q;
  logic [CW-1:0] lim0, lim1, lim2;
  logic [AW-1:0] off0_q, off1_q, off2_q;
  logic          w0, w1, w2;

  // A zero trip count behaves as a single iteration.
  assign lim0 = (range_0 == '0) ? '0 : range_0 - CW'(1);
  assign lim1 = (range_1 == '0) ? '0 : range_1 - CW'(1);
  assign lim2 = (range_2 == '0) ? '0 : range_2 - CW'(1);

  assign w0 = (i0_q == lim0);
  assign w1 = (i1_q == lim1);
  assign w2 = (i2_q == lim2);

  assign last_issue = w0 & w1 & w2;
  assign addr       = start + off0_q + off1_q + off2_q;

  // The outermost wrap comes from the owner asserting clr on the last point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i0_q <= '0; i1_q <= '0; i2_q <= '0;
      off0_q <= '0; off1_q <= '0; off2_q <= '0;
    end else if (clr) begin
      i0_q <= '0; i1_q <= '0; i2_q <= '0;
      off0_q <= '0; off1_q <= '0; off2_q <= '0;
    end else if (step) begin
      if (!w0) begin
        i0_q   <= i0_q + CW'(1);
        off0_q <= off0_q + AW'(stride_0);
      end else begin
        i0_q   <= '0;
        off0_q <= '0;
        if (!w1) begin
          i1_q   <= i1_q + CW'(1);
          off1_q <= off1_q + AW'(stride_1);
        end else begin
          i1_q   <= '0;
          off1_q <= '0;
          i2_q   <= i2_q + CW'(1);
          off2_q <= off2_q + AW'(stride_2);
        end
      end
    end
  end
endmodule

// File: rtl/db_read_sequencer_skid.sv
// Two-entry skid FIFO holding returned words while the consumer is not ready.
// Only built with DB_RD_BACKPRESSURE_EN.
`ifdef DB_RD_BACKPRESSURE_EN
module db_seq_skid #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  input  logic         rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);
  logic [1:0][W-1:0] mem_q;
  logic              wp_q, rp_q;
  logic [1:0]        cnt_q;
  logic              push, pop;

  assign pop     = en && rdy && (cnt_q != 2'd0);
  assign push    = en && in_vld && ((cnt_q != 2'd2) || pop);
  assign out_vld = (cnt_q != 2'd0);
  assign out_dat = mem_q[rp_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '0; wp_q <= 1'b0; rp_q <= 1'b0; cnt_q <= 2'd0;
    end else if (clr) begin
      mem_q <= '0; wp_q <= 1'b0; rp_q <= 1'b0; cnt_q <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= in_dat;
        wp_q        <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end
endmodule
`endif

// File: rtl/db_read_sequencer.sv
// Double-buffer read sequencer: fill tracking, bank swap, strided read issue, tile-tagged return path.
// Optional DB_RD_BACKPRESSURE_EN adds rdy_in gating of reads and a skid FIFO on the output.
module db_read_sequencer
  import db_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_en,
  input  logic          flush,
  input  logic [15:0]   depth,
  input  logic [AW-1:0] starting_addr,
  input  logic [15:0]   stride_0,
  input  logic [15:0]   stride_1,
  input  logic [15:0]   stride_2,
  input  logic [CW-1:0] range_0,
  input  logic [CW-1:0] range_1,
  input  logic [CW-1:0] range_2,
  input  logic [CW-1:0] iter_cnt,
  input  logic          wen_in,
  input  logic [DW-1:0] data_in_mem,
  input  logic          valid_in_mem,
`ifdef DB_RD_BACKPRESSURE_EN
  input  logic          rdy_in,
`endif
  output logic          ren_out,
  output logic [AW-1:0] addr_out,
  output logic          switch_db,
  output logic          rd_bank,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic          last_out,
  output logic          tile_done
);
  state_t        state_q;
  logic          fill_bank_q, rd_bank_q;
  logic [15:0]   wcnt_q;
  logic [CW-1:0] rcnt_q, retcnt_q;
  logic          ren_q, switch_q, tdone_q;
  logic [AW-1:0] addr_q;

  logic          full, sat, ret_done, drain_end, tile_end, swap, issue, fwd, last_ret;
  logic          agen_clr, agen_last;
  logic [AW-1:0] agen_addr;

  assign sat       = (wcnt_q == depth);
  assign full      = sat && (depth != 16'd0);
  assign ret_done  = (retcnt_q == iter_cnt);
  assign drain_end = (state_q == DRAIN) && (rcnt_q == iter_cnt);
  // Only a zero-length tile can have all returns in while still in DRAIN.
  assign tile_end  = ret_done && (drain_end || (state_q == WAIT));
  assign swap      = clk_en && full && ((state_q == FILL) || tile_end);
`ifdef DB_RD_BACKPRESSURE_EN
  assign issue     = clk_en && rdy_in && (state_q == DRAIN) && (rcnt_q != iter_cnt);
`else
  assign issue     = clk_en && (state_q == DRAIN) && (rcnt_q != iter_cnt);
`endif
  // Returns outside an active tile (e.g. stragglers after reset) are dropped.
  assign fwd       = clk_en && valid_in_mem && !ret_done &&
                     ((state_q == DRAIN) || (state_q == WAIT));
  assign last_ret  = (retcnt_q + CW'(1)) == iter_cnt;
  assign agen_clr  = flush || swap || (issue && agen_last);

  db_seq_agen #(.AW(AW), .CW(CW)) u_agen (
    .clk        (clk),
    .reset      (reset),
    .clr        (agen_clr),
    .step       (issue),
    .start      (starting_addr),
    .stride_0   (stride_0),
    .stride_1   (stride_1),
    .stride_2   (stride_2),
    .range_0    (range_0),
    .range_1    (range_1),
    .range_2    (range_2),
    .addr       (agen_addr),
    .last_issue (agen_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE; fill_bank_q <= 1'b0; rd_bank_q <= 1'b0; wcnt_q <= '0;
      rcnt_q <= '0; retcnt_q <= '0; ren_q <= 1'b0; addr_q <= '0;
      switch_q <= 1'b0; tdone_q <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE; fill_bank_q <= 1'b0; rd_bank_q <= 1'b0; wcnt_q <= '0;
      rcnt_q <= '0; retcnt_q <= '0; ren_q <= 1'b0; addr_q <= '0;
      switch_q <= 1'b0; tdone_q <= 1'b0;
    end else if (clk_en) begin
      ren_q    <= issue;
      switch_q <= swap;
      tdone_q  <= tile_end;
      if (issue) begin
        addr_q <= agen_addr;
        rcnt_q <= rcnt_q + CW'(1);
      end
      if (fwd) retcnt_q <= retcnt_q + CW'(1);
      // A write landing on the swap cycle belongs to the freshly opened fill bank.
      if (swap)                 wcnt_q <= wen_in ? 16'd1 : 16'd0;
      else if (wen_in && !sat)  wcnt_q <= wcnt_q + 16'd1;
      if (swap) begin
        rd_bank_q   <= fill_bank_q;
        fill_bank_q <= ~fill_bank_q;
        rcnt_q      <= '0;
        retcnt_q    <= '0;
      end
      case (state_q)
        IDLE:    if (depth != 16'd0) state_q <= FILL;
        FILL:    if (full) state_q <= DRAIN;
        DRAIN:   if (drain_end) state_q <= tile_end ? (full ? DRAIN : FILL) : WAIT;
        WAIT:    if (ret_done) state_q <= full ? DRAIN : FILL;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DB_RD_BACKPRESSURE_EN
  db_seq_skid #(.W(DW + 1)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .clr     (flush),
    .en      (clk_en),
    .in_vld  (fwd),
    .in_dat  ({last_ret, data_in_mem}),
    .rdy     (rdy_in),
    .out_vld (valid_out),
    .out_dat ({last_out, data_out})
  );
`else
  logic [DW-1:0] data_q;
  logic          valid_q, last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0; valid_q <= 1'b0; last_q <= 1'b0;
    end else if (flush) begin
      data_q <= '0; valid_q <= 1'b0; last_q <= 1'b0;
    end else if (clk_en) begin
      valid_q <= fwd;
      last_q  <= fwd && last_ret;
      if (fwd) data_q <= data_in_mem;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign last_out  = last_q;
`endif

  assign ren_out   = ren_q;
  assign addr_out  = addr_q;
  assign switch_db = switch_q;
  assign rd_bank   = rd_bank_q;
  assign tile_done = tdone_q;
endmodule

// File: tb/tb_db_read_sequencer.sv
// Scoreboard bench for db_read_sequencer: a latency-2 memory model answers reads and
// expected addresses/words/banks are queued from an index-based reference of the pattern.
module tb_db_read_sequencer;
  logic        clk = 1'b0, reset = 1'b1, clk_en = 1'b0, flush = 1'b0;
  logic [15:0] depth = '0, starting_addr = '0;
  logic [15:0] stride_0 = '0, stride_1 = '0, stride_2 = '0;
  logic [31:0] range_0 = '0, range_1 = '0, range_2 = '0, iter_cnt = '0;
  logic        wen_in = 1'b0;
  logic [15:0] data_in_mem = '0;
  logic        valid_in_mem = 1'b0;
  logic        ren_out, switch_db, rd_bank, valid_out, last_out, tile_done;
  logic [15:0] addr_out, data_out;

  db_read_sequencer dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .depth(depth),
    .starting_addr(starting_addr), .stride_0(stride_0), .stride_1(stride_1),
    .stride_2(stride_2), .range_0(range_0), .range_1(range_1), .range_2(range_2),
    .iter_cnt(iter_cnt), .wen_in(wen_in), .data_in_mem(data_in_mem),
    .valid_in_mem(valid_in_mem),
`ifdef DB_RD_BACKPRESSURE_EN
    .rdy_in(1'b1),
`endif
    .ren_out(ren_out), .addr_out(addr_out), .switch_db(switch_db), .rd_bank(rd_bank),
    .data_out(data_out), .valid_out(valid_out), .last_out(last_out), .tile_done(tile_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0, ren_seen = 0, sw_cnt = 0, td_cnt = 0, sw_cyc = 0, td_cyc = 0;
  logic en_last = 1'b0;
  logic [15:0] exp_addr[$];
  logic [16:0] exp_data[$];
  logic        exp_bank[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] memf(logic b, logic [15:0] a);
    logic [15:0] k;
    k = {b, 15'h0};
    return a ^ k ^ 16'h3c5a;
  endfunction

  // Memory: registered, two enabled cycles from ren_out to valid_in_mem. Not reset on purpose.
  logic        m_v = 1'b0;
  logic [15:0] m_d = '0;
  always @(posedge clk) begin
    cyc++;
    en_last = clk_en;
    if (clk_en) begin
      m_v          <= ren_out;
      m_d          <= memf(rd_bank, addr_out);
      valid_in_mem <= m_v;
      data_in_mem  <= m_d;
    end
  end

  always @(negedge clk) begin
    if (en_last && !reset) begin
      if (ren_out) begin
        ren_seen++;
        if (exp_addr.size() == 0) chk("ren_unexp", 32'(ren_out), 0);
        else chk("addr", 32'(addr_out), 32'(exp_addr.pop_front()));
      end
      if (valid_out) begin
        if (exp_data.size() == 0) chk("valid_unexp", 32'(valid_out), 0);
        else chk("data_last", 32'({last_out, data_out}), 32'(exp_data.pop_front()));
      end
      if (switch_db) begin
        sw_cnt++; sw_cyc = cyc;
        if (exp_bank.size() == 0) chk("switch_unexp", 32'(switch_db), 0);
        else chk("rd_bank", 32'(rd_bank), 32'(exp_bank.pop_front()));
      end
      if (tile_done) begin
        td_cnt++; td_cyc = cyc;
      end
    end
  end

  task automatic push_tile(logic b, logic [15:0] st, int s0, int s1, int s2,
                           int r0, int r1, int r2, int it);
    int e0, e1, e2, i0, i1, i2;
    logic [15:0] a;
    e0 = (r0 == 0) ? 1 : r0;
    e1 = (r1 == 0) ? 1 : r1;
    e2 = (r2 == 0) ? 1 : r2;
    exp_bank.push_back(b);
    for (int n = 0; n < it; n++) begin
      i0 = n % e0;
      i1 = (n / e0) % e1;
      i2 = (n / (e0 * e1)) % e2;
      a  = st + 16'(i0 * s0 + i1 * s1 + i2 * s2);
      exp_addr.push_back(a);
      exp_data.push_back({(n == it - 1), memf(b, a)});
    end
  endtask

  task automatic cfg(int d, int st, int s0, int s1, int s2, int r0, int r1, int r2, int it);
    @(negedge clk);
    flush = 1'b1;
    depth = 16'(d); starting_addr = 16'(st);
    stride_0 = 16'(s0); stride_1 = 16'(s1); stride_2 = 16'(s2);
    range_0 = r0; range_1 = r1; range_2 = r2; iter_cnt = it;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_rd_bank", 32'(rd_bank), 0);
    chk("flush_ren", 32'(ren_out), 0);
  endtask

  task automatic do_wr(int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      wen_in = 1'b1;
    end
    @(negedge clk);
    wen_in = 1'b0;
  endtask

  task automatic wait_td(int tgt, int budget);
    int k;
    k = 0;
    while (td_cnt < tgt && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk("tile_done_cnt", td_cnt, tgt);
    chk("sb_data_left", exp_data.size(), 0);
  endtask

  task automatic wait_ren(int tgt);
    int k;
    k = 0;
    while (ren_seen < tgt && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("ren_reached", 32'(ren_seen >= tgt), 1);
  endtask

  logic [15:0] s_addr, s_data;
  logic        s_val, s_ren;
  int          base, sw_base;

  initial begin
    // Reset state
    #3;
    chk("rst_ren", 32'(ren_out), 0);
    chk("rst_addr", 32'(addr_out), 0);
    chk("rst_switch", 32'(switch_db), 0);
    chk("rst_rd_bank", 32'(rd_bank), 0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_tile_done", 32'(tile_done), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0; clk_en = 1'b1;

    // Linear tile
    cfg(27, 0, 1, 3, 9, 3, 3, 3, 27);
    push_tile(1'b0, 16'd0, 1, 3, 9, 3, 3, 3, 27);
    do_wr(27);
    wait_td(1, 200);
    chk("lin_switch_cnt", sw_cnt, 1);

    // Concurrent fill: second bank fills during the first drain
    push_tile(1'b1, 16'd0, 1, 3, 9, 3, 3, 3, 27);
    push_tile(1'b0, 16'd0, 1, 3, 9, 3, 3, 3, 27);
    do_wr(54);
    wait_td(3, 400);
    chk("conc_switch_cnt", sw_cnt, 3);
    chk("conc_bank_left", exp_bank.size(), 0);

    // Transposed tile, range_2 = 0 acts as 1
    cfg(9, 0, 3, 1, 9, 3, 3, 0, 9);
    push_tile(1'b0, 16'd0, 3, 1, 9, 3, 3, 0, 9);
    do_wr(9);
    wait_td(4, 150);

    // Stall mid-drain
    cfg(27, 100, 1, 3, 9, 3, 3, 3, 27);
    push_tile(1'b0, 16'd100, 1, 3, 9, 3, 3, 3, 27);
    base = ren_seen;
    do_wr(27);
    wait_ren(base + 8);
    s_addr = addr_out; s_data = data_out; s_val = valid_out; s_ren = ren_out;
    clk_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_addr", 32'(addr_out), 32'(s_addr));
      chk("stall_valid", 32'(valid_out), 32'(s_val));
      chk("stall_data", 32'(data_out), 32'(s_data));
      chk("stall_ren", 32'(ren_out), 32'(s_ren));
    end
    clk_en = 1'b1;
    wait_td(5, 200);

    // Mid-tile asynchronous reset
    cfg(27, 0, 1, 3, 9, 3, 3, 3, 27);
    push_tile(1'b0, 16'd0, 1, 3, 9, 3, 3, 3, 27);
    base = ren_seen;
    do_wr(27);
    wait_ren(base + 10);
    #2 reset = 1'b1;
    #1;
    chk("arst_ren", 32'(ren_out), 0);
    chk("arst_addr", 32'(addr_out), 0);
    chk("arst_valid", 32'(valid_out), 0);
    chk("arst_data", 32'(data_out), 0);
    chk("arst_last", 32'(last_out), 0);
    chk("arst_switch", 32'(switch_db), 0);
    exp_addr.delete(); exp_data.delete(); exp_bank.delete();
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("late_valid", 32'(valid_out), 0);
      chk("late_ren", 32'(ren_out), 0);
    end

    // iter_cnt = 0: swap then tile_done one cycle later, no reads
    cfg(4, 0, 1, 1, 1, 1, 1, 1, 0);
    exp_bank.push_back(1'b0);
    base = ren_seen;
    do_wr(4);
    wait_td(6, 50);
    chk("zero_td_lat", td_cyc - sw_cyc, 1);
    chk("zero_no_ren", ren_seen, base);

    // depth = 0: stays idle
    cfg(0, 0, 1, 1, 1, 1, 1, 1, 4);
    sw_base = sw_cnt; base = ren_seen;
    do_wr(5);
    repeat (10) @(negedge clk);
    chk("depth0_switch", sw_cnt, sw_base);
    chk("depth0_ren", ren_seen, base);
    chk("final_addr_left", exp_addr.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/db_read_sequencer.md
Name: db_read_sequencer

Overview:
- Read-side sequencer for the double-buffered memory core, in mode 3 (DB).
- Tracks writer-side fills per bank and issues `switch_db` when a bank is full.
- Generates a 3-D strided read address stream (`ren_out`/`addr_out`) for the drained bank.
- Forwards returned data with a per-tile `last` marker, so a checker or downstream PE can consume exactly `iter_cnt` words per tile.

Parameters:
- DW, 16, data width.
- AW, 16, address width (per-bank offset).
- CW, 32, width of `iter_cnt` and range counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- clk_en  in  1  global clock enable; all state holds when 0
- flush  in  1  synchronous soft reset, same effect as reset
- depth  in  16  words per bank; static while not IDLE
- starting_addr  in  AW  base offset of read pattern
- stride_0 / stride_1 / stride_2  in  16  per-dimension address strides
- range_0 / range_1 / range_2  in  CW  per-dimension trip counts; 0 treated as 1
- iter_cnt  in  CW  reads per tile
- wen_in  in  1  writer strobe into fill bank
- data_in_mem  in  DW  memory read data
- valid_in_mem  in  1  memory read data valid
- ren_out  out  1  read enable to memory
- addr_out  out  AW  read offset in drain bank
- switch_db  out  1  one-cycle bank swap pulse
- rd_bank  out  1  bank currently drained
- data_out  out  DW  registered read data
- valid_out  out  1  `data_out` valid
- last_out  out  1  with `valid_out`, final word of tile
- tile_done  out  1  one-cycle pulse after last word returned

Behaviour:
- Reset/flush values:
  - Outputs: all outputs 0; `rd_bank` = 0.
  - Internal: state IDLE; counters 0; fill bank = 0.
- Write counting:
  - `wcnt` increments on `clk_en & wen_in` and saturates at `depth`.
  - Bank is full when `wcnt == depth`. Writes while full are ignored (counted as protocol error, no state change).
- FSM (advances only on `clk_en`):
  - IDLE: `depth == 0` -> stay. Else -> FILL.
  - FILL: bank full -> pulse `switch_db`, `rd_bank <= fill bank`, fill bank toggles, `wcnt` cleared -> DRAIN.
  - DRAIN:
    - Assert `ren_out` every enabled cycle until `rcnt == iter_cnt`, then -> WAIT.
    - Address: `addr_out = starting_addr + i0*stride_0 + i1*stride_1 + i2*stride_2`, truncated mod 2^AW.
    - Iteration: `i0` innermost; `i0` wraps at `range_0` and carries into `i1`; `i1` wraps at `range_1` and carries into `i2`.
  - WAIT:
    - Holds until returned-word count equals `iter_cnt`; then `tile_done` pulse.
    - If next bank is already full: swap in the same cycle -> DRAIN.
    - Otherwise -> FILL.
- Concurrency:
  - Writer fills the other bank concurrently during DRAIN/WAIT.
  - Fill completing before drain finishes sets `pend_full`; the swap is deferred until WAIT exits.
  - `wen_in` coincident with the swap cycle counts into the new fill bank.
- Read path: memory latency is arbitrary ≥1. `data_out`/`valid_out` register `data_in_mem`/`valid_in_mem` (1-cycle latency). `last_out` is set on the `iter_cnt`-th valid word.
- Zero reads: `iter_cnt == 0` -> DRAIN goes directly to WAIT with no `ren`; `tile_done` fires next cycle.
- Reset mid-tile: in-flight returns after reset are dropped (`valid_out` stays 0).
- Overflow: address arithmetic is not checked; wrap is legal.

Optional Feature:
- Macro: `DB_RD_BACKPRESSURE_EN`.
- With the macro:
  - Adds input `rdy_in` (1).
  - `ren_out` is gated by `rdy_in`; address and iteration counters advance only on `ren_out & clk_en`.
  - `valid_out` is held with stable data until `rdy_in`, using a 2-entry skid FIFO (sub-module).
- Without the macro:
  - No `rdy_in` port.
  - `ren_out` is issued every enabled DRAIN cycle; output is never stalled.

Decomposition:
- Package `db_seq_pkg`:
  - `state_t` enum {IDLE, FILL, DRAIN, WAIT}.
  - DW/AW/CW default localparams.
  - `MODE_DB = 2'h3` constant.
- One sub-module, `db_seq_agen`: the 3-D nested counter plus stride accumulator (incremental adds, no multipliers). Outputs address and `last_issue`.

Test Plan:
- Linear tile.
  - Stimulus: depth=27, strides 1/3/9, ranges 3/3/3, iter_cnt=27, 27 writes.
  - Expect: one `switch_db`; `addr_out` 0..26 in order; 27 `valid_out`; `last_out` on 27th; `tile_done` once.
- Transposed tile.
  - Stimulus: strides 3/1/9, ranges 3/3/1, iter_cnt=9, depth=9.
  - Expect: addresses 0,3,6,1,4,7,2,5,8.
- Concurrent fill/drain.
  - Stimulus: second 27 writes during first DRAIN.
  - Expect: second swap immediately at WAIT exit; `rd_bank` toggles 0→1→0.
- Stall.
  - Stimulus: `clk_en` low 5 cycles mid-DRAIN.
  - Expect: `addr_out`, counters, and `valid_out` frozen; sequence resumes unchanged.
- Mid-tile reset.
  - Stimulus: reset asserted after 10 reads.
  - Expect: all outputs 0 the same cycle (async); IDLE; late memory returns not forwarded.
- Edge cases.
  - Stimulus: iter_cnt=0 or depth=0.
  - Expect: no `ren_out`. For iter_cnt=0, `tile_done` pulse 1 cycle after swap. For depth=0, stays IDLE.
